// File: rtl/dco_word_slew_ctrl.sv
// DCO tuning-word slew controller.
// Accepts a clamped target word and walks word_out toward it in steps of at
// most MAX_STEP LSBs, settling SETTLE_CYC cycles after each step. Every step
// is followed by a one-cycle cod_en so the row/col coder registers the new word.
//
// state  | meaning
// IDLE   | ramp complete, ready for a new target
// STEP   | apply one bounded step (held while freeze is high)
// SETTLE | wait for the capacitor bank to settle after a step
module dco_word_slew_ctrl #(
    parameter int WORD_W     = 8,
    parameter int MAX_STEP   = 16,
    parameter int SETTLE_CYC = 4,
    parameter int MIN_WORD   = 0,
    parameter int MAX_WORD   = 255,
    parameter int RST_WORD   = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] tgt_word,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic              freeze,
    output logic [WORD_W-1:0] word_out,
    output logic              cod_en,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE
    } state_t;

    localparam logic [WORD_W-1:0] MIN_W    = WORD_W'(MIN_WORD);
    localparam logic [WORD_W-1:0] MAX_W    = WORD_W'(MAX_WORD);
    localparam logic [WORD_W-1:0] RST_W    = WORD_W'(RST_WORD);
    localparam logic [WORD_W-1:0] STEP_W   = WORD_W'(MAX_STEP);
    localparam logic [7:0]        SETTLE_W = 8'(SETTLE_CYC);

    state_t            state, state_nxt;
    logic [WORD_W-1:0] word_q, word_nxt;
    logic [WORD_W-1:0] target_q, target_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic              cod_en_q, cod_en_nxt;
    logic              done_q, done_nxt;

    logic [WORD_W-1:0] tclamp;
    logic [WORD_W:0]   diff;
    logic [WORD_W:0]   mag;
    logic              down;
    logic [WORD_W-1:0] step_amt;
    logic [WORD_W-1:0] word_step;

    // Clamp the requested word into the legal bank range.
    always_comb begin
        tclamp = tgt_word;
        if (int'(tgt_word) < MIN_WORD) begin
            tclamp = MIN_W;
        end else if (int'(tgt_word) > MAX_WORD) begin
            tclamp = MAX_W;
        end
    end

    // Next word one bounded step toward the target; never overshoots or wraps.
    always_comb begin
        diff      = {1'b0, target_q} - {1'b0, word_q};
        down      = diff[WORD_W];
        mag       = down ? (~diff + 1'b1) : diff;
        step_amt  = (mag > {1'b0, STEP_W}) ? STEP_W : mag[WORD_W-1:0];
        word_step = down ? (word_q - step_amt) : (word_q + step_amt);
    end

    // Sequencer next-state and registered-output decode.
    always_comb begin
        state_nxt  = state;
        word_nxt   = word_q;
        target_nxt = target_q;
        cnt_nxt    = cnt_q;
        cod_en_nxt = 1'b0;
        done_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    target_nxt = tclamp;
                    if (tclamp == word_q) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = STEP;
                    end
                end
            end
            STEP: begin
                if (!freeze) begin
                    word_nxt   = word_step;
                    cod_en_nxt = 1'b1;
                    cnt_nxt    = 8'd1;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q < SETTLE_W) begin
                    cnt_nxt = cnt_q + 8'd1;
                end else if (word_q == target_q) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = STEP;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_q   <= RST_W;
            target_q <= RST_W;
            cnt_q    <= 8'd0;
            cod_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_q   <= word_nxt;
            target_q <= target_nxt;
            cnt_q    <= cnt_nxt;
            cod_en_q <= cod_en_nxt;
            done_q   <= done_nxt;
        end
    end

    assign word_out  = word_q;
    assign cod_en    = cod_en_q;
    assign done      = done_q;
    assign tgt_ready = (state == IDLE);
    assign busy      = (state == STEP) || (state == SETTLE);

endmodule
